// File: rtl/ct_spsram_pkg.sv
// Shared types and helpers for the ct_f_spsram_rmw_wrap SRAM wrapper.
// The optional zero-fill after reset is enabled with the macro CT_SPSRAM_INIT_EN.
package ct_spsram_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RMW
  } state_e;

  // How a bank should treat one write request, based on its slice of the active-low WEN.
  typedef enum logic [1:0] {
    MASK_ALL_WR,
    MASK_NONE,
    MASK_MIXED
  } mask_cls_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_DIRECT,
    OP_RMW,
    OP_ZERO
  } bank_op_e;

  function automatic int nbank(input int data_width, input int wrap_size);
    return data_width / wrap_size;
  endfunction

  function automatic mask_cls_e mask_class(input logic all_set, input logic any_set);
    if (!any_set) return MASK_ALL_WR;
    else if (all_set) return MASK_NONE;
    else return MASK_MIXED;
  endfunction

endpackage

// File: rtl/ct_f_spsram_rmw_wrap_if.sv
// Request/response bus of the ct_f_spsram_rmw_wrap SRAM wrapper.
interface ct_f_spsram_rmw_wrap_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 54
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  BUSY;

  modport master (output A, CEN, GWEN, WEN, D, input Q, BUSY);
  modport slave  (input A, CEN, GWEN, WEN, D, output Q, BUSY);
endinterface

// File: rtl/ct_spsram_bank.sv
// One WRAP_SIZE-bit bank: block RAM plus its write-enable decode and read-modify-write merge.
module ct_spsram_bank
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int WRAP_SIZE  = 27
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  bank_op_e              op,
  input  logic [WRAP_SIZE-1:0]  live_wen,
  input  logic [WRAP_SIZE-1:0]  live_d,
  input  logic [WRAP_SIZE-1:0]  hold_wen,
  input  logic [WRAP_SIZE-1:0]  hold_d,
  output mask_cls_e             live_cls,
  output logic [WRAP_SIZE-1:0]  rdata
);

  mask_cls_e            hold_cls;
  logic                 we;
  logic [WRAP_SIZE-1:0] wdata;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    live_cls = mask_class(&live_wen, |live_wen);
    hold_cls = mask_class(&hold_wen, |hold_wen);
    we       = 1'b0;
    wdata    = live_d;
    unique case (op)
      OP_DIRECT: we = (live_cls == MASK_ALL_WR);
      OP_RMW: begin
        // rdata is the old word fetched during the accept cycle
        we    = (hold_cls != MASK_NONE);
        wdata = (rdata & hold_wen) | (hold_d & ~hold_wen);
      end
      OP_ZERO: begin
        we    = 1'b1;
        wdata = '0;
      end
      default: ;
    endcase
  end

  my_fpga_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(WRAP_SIZE)
  ) u_ram (
    .clk (clk),
    .addr(addr),
    .we  (we),
    .din (wdata),
    .dout(rdata)
  );

endmodule

// File: rtl/my_fpga_ram.sv
// Single-port synchronous FPGA block RAM, read-first: dout shows the pre-write contents.
module my_fpga_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 27
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // NOTE: the storage array has no reset so it maps onto block RAM; clearing it is the INIT state's job.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: non-blocking assignments here make the read return the old word when addr is also written.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/ct_f_spsram_rmw_wrap.sv
// Parametrised single-port SRAM wrapper with per-bit write mask via internal read-modify-write.
// Define CT_SPSRAM_INIT_EN to zero-fill the whole array after reset (BUSY held meanwhile).
module ct_f_spsram_rmw_wrap
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 54,
  parameter int WRAP_SIZE  = 27
) (
  input  logic                    CLK,
  input  logic                    RST,
  ct_f_spsram_rmw_wrap_if.slave   bus
);

  localparam int NBANK = nbank(DATA_WIDTH, WRAP_SIZE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, bank_addr;
  logic [DATA_WIDTH-1:0] d_q, d_d, wen_q, wen_d, q_q, q_d, rdata;
  logic                  rd_pend_q, rd_pend_d;
  logic                  busy, accept, any_mixed;
  logic [NBANK-1:0]      mixed;
  mask_cls_e             live_cls [NBANK];
  bank_op_e              bank_op;

`ifdef CT_SPSRAM_INIT_EN
  localparam int     DEPTH     = 2**ADDR_WIDTH;
  localparam state_e RST_STATE = ST_INIT;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    ct_spsram_bank #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .WRAP_SIZE (WRAP_SIZE)
    ) u_bank (
      .clk     (CLK),
      .addr    (bank_addr),
      .op      (bank_op),
      .live_wen(bus.WEN[b*WRAP_SIZE +: WRAP_SIZE]),
      .live_d  (bus.D[b*WRAP_SIZE +: WRAP_SIZE]),
      .hold_wen(wen_q[b*WRAP_SIZE +: WRAP_SIZE]),
      .hold_d  (d_q[b*WRAP_SIZE +: WRAP_SIZE]),
      .live_cls(live_cls[b]),
      .rdata   (rdata[b*WRAP_SIZE +: WRAP_SIZE])
    );
    assign mixed[b] = (live_cls[b] == MASK_MIXED);
  end

  assign any_mixed = |mixed;
  assign busy      = (state_q != ST_IDLE);
  assign accept    = !RST && !bus.CEN && !busy;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= RST_STATE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef CT_SPSRAM_INIT_EN
      ST_INIT: if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_IDLE;
`else
      ST_INIT: state_d = ST_IDLE;
`endif
      ST_IDLE: if (accept && !bus.GWEN && any_mixed) state_d = ST_RMW;
      ST_RMW:  state_d = ST_IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  // A mixed-mask accept issues only the read; all of its writes land in the RMW cycle.
  always_comb begin
    bank_op   = OP_NONE;
    bank_addr = accept ? bus.A : addr_q;
    unique case (state_q)
`ifdef CT_SPSRAM_INIT_EN
      ST_INIT: begin
        bank_op   = OP_ZERO;
        bank_addr = cnt_q;
      end
`endif
      ST_IDLE: if (accept && !bus.GWEN && !any_mixed) bank_op = OP_DIRECT;
      ST_RMW:  if (!RST) bank_op = OP_RMW;
      default: ;
    endcase
  end

  always_comb begin
    addr_d    = accept ? bus.A : addr_q;
    d_d       = d_q;
    wen_d     = wen_q;
    if (accept && !bus.GWEN && any_mixed) begin
      d_d   = bus.D;
      wen_d = bus.WEN;
    end
    rd_pend_d = accept && bus.GWEN;
    q_d       = rd_pend_q ? rdata : q_q;
`ifdef CT_SPSRAM_INIT_EN
    cnt_d     = cnt_q;
    if (state_q == ST_INIT && cnt_q != ADDR_WIDTH'(DEPTH - 1)) cnt_d = cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q    <= '0;
      d_q       <= '0;
      wen_q     <= '0;
      rd_pend_q <= 1'b0;
      q_q       <= '0;
`ifdef CT_SPSRAM_INIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      addr_q    <= addr_d;
      d_q       <= d_d;
      wen_q     <= wen_d;
      rd_pend_q <= rd_pend_d;
      q_q       <= q_d;
`ifdef CT_SPSRAM_INIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.Q    = q_d;
  assign bus.BUSY = busy;

endmodule

// File: tb/tb_ct_f_spsram_rmw_wrap.sv
// Directed self-checking bench for ct_f_spsram_rmw_wrap (9-bit address, 54-bit word, 27-bit banks).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ct_f_spsram_rmw_wrap;

  localparam logic [53:0] ONES = 54'h3FFFFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ct_f_spsram_rmw_wrap_if #(.ADDR_WIDTH(9), .DATA_WIDTH(54)) bus ();

  ct_f_spsram_rmw_wrap #(
    .ADDR_WIDTH(9),
    .DATA_WIDTH(54),
    .WRAP_SIZE (27)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.CEN  = 1'b1;
    bus.GWEN = 1'b1;
    bus.WEN  = ONES;
    bus.D    = '0;
  endtask

  task automatic drive_wr(input logic [8:0] a, input logic [53:0] d, input logic [53:0] wen);
    bus.CEN  = 1'b0;
    bus.GWEN = 1'b0;
    bus.A    = a;
    bus.D    = d;
    bus.WEN  = wen;
  endtask

  task automatic drive_rd(input logic [8:0] a);
    bus.CEN  = 1'b0;
    bus.GWEN = 1'b1;
    bus.A    = a;
    bus.WEN  = ONES;
    bus.D    = '0;
  endtask

  task automatic test_reset();
    int busy_cycles;
    rst = 1'b1;
    bus.A = '0;
    drive_idle();
    repeat (3) tick();
    n_checks++;
    if (bus.Q !== 54'h0) begin
      n_fail++; $display("FAIL reset_q: got %h want %h", bus.Q, 54'h0);
    end
`ifdef CT_SPSRAM_INIT_EN
    n_checks++;
    if (bus.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b want 1", bus.BUSY);
    end
    rst = 1'b0;
    busy_cycles = 0;
    while (bus.BUSY === 1'b1 && busy_cycles < 2000) begin
      busy_cycles++;
      tick();
    end
    n_checks++;
    if (busy_cycles !== 512) begin
      n_fail++; $display("FAIL init_busy_len: got %0d want 512", busy_cycles);
    end
    drive_rd(9'h1FF);
    tick();
    n_checks++;
    if (bus.Q !== 54'h0) begin
      n_fail++; $display("FAIL init_read_1ff: got %h want %h", bus.Q, 54'h0);
    end
`else
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSY);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_busy: got %b want 0", bus.BUSY);
    end
`endif
  endtask

  task automatic test_full_write();
    drive_wr(9'h005, ONES, 54'h0);
    tick();
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL full_wr_busy: got %b want 0", bus.BUSY);
    end
    drive_rd(9'h005);
    tick();
    n_checks++;
    if (bus.Q !== ONES) begin
      n_fail++; $display("FAIL full_wr_q: got %h want %h", bus.Q, ONES);
    end
    // Upper bank masked off entirely, lower bank fully written: still single cycle.
    drive_wr(9'h007, 54'h123456789ABCDE, 54'h0);
    tick();
    drive_wr(9'h007, 54'h0, {27'h7FFFFFF, 27'h0});
    tick();
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL bank_none_busy: got %b want 0", bus.BUSY);
    end
    drive_rd(9'h007);
    tick();
    n_checks++;
    if (bus.Q !== 54'h12345678000000) begin
      n_fail++; $display("FAIL bank_none_q: got %h want %h", bus.Q, 54'h12345678000000);
    end
  endtask

  task automatic test_rmw();
    drive_wr(9'h010, ONES, 54'h0);
    tick();
    drive_wr(9'h020, 54'h2AAAAAAAAAAAAA, 54'h0);
    tick();
    drive_wr(9'h010, 54'h0, 54'h3FFFFFFFFFFF0F);
    tick();
    n_checks++;
    if (bus.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL rmw_busy: got %b want 1", bus.BUSY);
    end
    drive_wr(9'h020, 54'h1, 54'h0);
    tick();
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rmw_busy_clear: got %b want 0", bus.BUSY);
    end
    n_checks++;
    if (bus.Q !== 54'h12345678000000) begin
      n_fail++; $display("FAIL rmw_q_hold: got %h want %h", bus.Q, 54'h12345678000000);
    end
    drive_rd(9'h010);
    tick();
    n_checks++;
    if (bus.Q !== 54'h3FFFFFFFFFFF0F) begin
      n_fail++; $display("FAIL rmw_merged: got %h want %h", bus.Q, 54'h3FFFFFFFFFFF0F);
    end
    drive_rd(9'h020);
    tick();
    n_checks++;
    if (bus.Q !== 54'h2AAAAAAAAAAAAA) begin
      n_fail++; $display("FAIL rmw_dropped_wr: got %h want %h", bus.Q, 54'h2AAAAAAAAAAAAA);
    end
  endtask

  task automatic test_rmw_read_retry();
    drive_wr(9'h030, 54'h0, 54'h0);
    tick();
    drive_wr(9'h030, ONES, 54'h3FFFFFF0000000);
    tick();
    n_checks++;
    if (bus.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL retry_busy: got %b want 1", bus.BUSY);
    end
    drive_rd(9'h030);
    tick();
    n_checks++;
    if (bus.Q !== 54'h2AAAAAAAAAAAAA) begin
      n_fail++; $display("FAIL retry_dropped_q: got %h want %h", bus.Q, 54'h2AAAAAAAAAAAAA);
    end
    tick();
    n_checks++;
    if (bus.Q !== 54'h0000000FFFFFFF) begin
      n_fail++; $display("FAIL retry_q: got %h want %h", bus.Q, 54'h0000000FFFFFFF);
    end
  endtask

  task automatic test_q_hold();
    drive_rd(9'h005);
    tick();
    n_checks++;
    if (bus.Q !== ONES) begin
      n_fail++; $display("FAIL hold_read: got %h want %h", bus.Q, ONES);
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.Q !== ONES) begin
        n_fail++; $display("FAIL hold_idle%0d: got %h want %h", i, bus.Q, ONES);
      end
    end
    drive_wr(9'h006, 54'h15, 54'h0);
    tick();
    drive_idle();
    tick();
    n_checks++;
    if (bus.Q !== ONES) begin
      n_fail++; $display("FAIL hold_write: got %h want %h", bus.Q, ONES);
    end
  endtask

  task automatic test_back_to_back();
    logic [53:0] data [4];
    data[0] = 54'h11111111111111;
    data[1] = 54'h22222222222222;
    data[2] = 54'h33333333333333;
    data[3] = 54'h04040404040404;
    for (int i = 0; i < 4; i++) begin
      drive_wr(9'h040 + 9'(i), data[i], 54'h0);
      tick();
      n_checks++;
      if (bus.BUSY !== 1'b0) begin
        n_fail++; $display("FAIL b2b_wr_busy%0d: got %b want 0", i, bus.BUSY);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_rd(9'h040 + 9'(i));
      tick();
      n_checks++;
      if (bus.Q !== data[i]) begin
        n_fail++; $display("FAIL b2b_rd%0d: got %h want %h", i, bus.Q, data[i]);
      end
    end
  endtask

  task automatic test_rst_in_rmw();
    int busy_cycles;
    drive_wr(9'h010, 54'h0, 54'h3FFFFFFFFFFFF0);
    tick();
    n_checks++;
    if (bus.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL rstrmw_busy: got %b want 1", bus.BUSY);
    end
    rst = 1'b1;
    drive_idle();
    tick();
    n_checks++;
    if (bus.Q !== 54'h0) begin
      n_fail++; $display("FAIL rstrmw_q: got %h want %h", bus.Q, 54'h0);
    end
    rst = 1'b0;
`ifdef CT_SPSRAM_INIT_EN
    busy_cycles = 0;
    while (bus.BUSY === 1'b1 && busy_cycles < 2000) begin
      busy_cycles++;
      tick();
    end
    n_checks++;
    if (busy_cycles !== 512) begin
      n_fail++; $display("FAIL rstrmw_init_len: got %0d want 512", busy_cycles);
    end
    drive_wr(9'h011, ONES, 54'h0);
    tick();
    drive_rd(9'h011);
    tick();
    n_checks++;
    if (bus.Q !== ONES) begin
      n_fail++; $display("FAIL rstrmw_wr11: got %h want %h", bus.Q, ONES);
    end
    drive_rd(9'h010);
    tick();
    n_checks++;
    if (bus.Q !== 54'h0) begin
      n_fail++; $display("FAIL rstrmw_zeroed: got %h want %h", bus.Q, 54'h0);
    end
`else
    busy_cycles = 0;
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rstrmw_busy_after: got %b want 0 (%0d)", bus.BUSY, busy_cycles);
    end
    drive_rd(9'h010);
    tick();
    n_checks++;
    if (bus.Q !== 54'h3FFFFFFFFFFF0F) begin
      n_fail++; $display("FAIL rstrmw_unmodified: got %h want %h", bus.Q, 54'h3FFFFFFFFFFF0F);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_rmw();
    test_rmw_read_retry();
    test_q_hold();
    test_back_to_back();
    test_rst_in_rmw();
    drive_idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
